arm_prog_encoder: RTL and testbench
===================================

# arm_prog_encoder

Streaming instruction encoder and program loader. Accepts decoded instruction descriptors over a valid/ready handshake, packs each into the 32-bit ARM machine word that the processor's instruction decoder consumes, and writes it sequentially into instruction memory. It sits between the test/boot host and the imem write port. On `finish` it appends a branch-to-self terminator, then reports done; illegal descriptors halt loading with an error code.

## Interface
Parameters:
- `ADDR_W`, 6: imem word-address width; DEPTH = 2^ADDR_W words.
- `BASE`, 0: first word address written after `start`.

Ports:
- `clk` in 1: clock; one clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; honored only in IDLE, DONE, ERR.
- `finish` in 1: end of program; honored only in RUN.
- `op_valid` in 1 / `op_ready` out 1: descriptor handshake; transfer when both are high on a rising edge.
- `op_class` in 2: 00 DP, 01 MEM, 10 BR, 11 illegal.
- `op_cond` in 4: condition field, bits [31:28].
- `op_cmd` in 4: DP command: AND 0000, EOR 0001, SUB 0010, ADD 0100, TST 1000, CMP 1010, ORR 1100, MOV 1101.
- `op_s`, `op_imm`, `op_load`, `op_byte`, `op_up` in 1 each: S bit, immediate source2, LDR vs STR, byte access, add offset.
- `op_rd`, `op_rn`, `op_rm` in 4 each: register numbers.
- `op_shamt` in 5: LSL amount, register-source DP only.
- `op_imm12` in 12: DP immediate uses [7:0] with rotate 0; MEM offset uses all 12 bits.
- `op_imm24` in 24: branch word offset.
- `imem_we` out 1, `imem_addr` out ADDR_W, `imem_wdata` out 32: registered imem write port.
- `busy`, `done`, `error` out 1 each; `err_code` out 2; `word_count` out ADDR_W+1.

## Operation
- FSM states: IDLE → RUN on `start`, which sets addr to BASE and count to 0. RUN → TERM on `finish`. RUN → ERR on an accepted illegal descriptor. TERM → DONE after one cycle. DONE/ERR → RUN on `start`.
- `op_ready` = (state==RUN) && (count < DEPTH−BASE−1); one slot is always reserved for the terminator.
- DP encoding: cond, 00, I, cmd, S, Rn, Rd, src2.
  - Immediate src2: {4'b0, imm12[7:0]}.
  - Register src2: {shamt, 2'b00, 0, Rm}.
  - CMP/TST force S=1 and Rd=0. MOV forces Rn=0.
- MEM encoding: cond, 01, ~I, P=1, U, B, W=0, L, Rn, Rd, src2. Register form: {7'b0, 1'b0, Rm} with shift 0.
- BR encoding: cond, 1010, imm24.
- Terminator word: 32'hEAFFFFFE, written at the current address.
- Errors are checked on the accepted descriptor. Nothing is written and the FSM enters ERR.
  - 01: DP immediate with imm12[11:8] ≠ 0.
  - 10: DP cmd outside the listed set.
  - 11: op_class==11.
- `busy` = RUN or TERM. `done` is high in DONE. `error`/`err_code` are held in ERR and cleared by `start`.
- `word_count` counts words written, including the terminator.

## Timing
- Reset: state IDLE; `op_ready`, `imem_we`, `busy`, `done`, `error` = 0; `err_code` = 0; `imem_addr` = BASE; `imem_wdata` = 0; `word_count` = 0.
- Latency: `imem_we` pulses exactly one cycle after acceptance, with addr/data for that word. Throughput is one word per cycle.
- `imem_addr` increments after each write; it never wraps, because the reservation rule prevents it.
- `finish` together with a valid transfer in the same cycle: the op is encoded first (cycle N+1), then the terminator (cycle N+2).
- `finish` while full (op_ready=0): the terminator goes to the reserved slot.
- `start` in RUN/TERM is ignored.
- Reset asserted mid-load: everything returns to reset values immediately; an in-flight write is dropped.

## Structure
- Package `arm_enc_pkg`: op_class enum, DP cmd constants (shared values with the ALU decoder), FSM state enum, TERM_WORD, err_code constants.
- Sub-module `arm_word_encode`: combinational field packer plus legality check, returning word and err. The top holds the FSM, counters, and output registers.

## Test plan
- `start`; ADD R1,R2,#5 (cond E, imm, S=0) → next cycle we=1, addr=0, data=32'hE2821005.
- CMP R3,R4 register form, S input 0 → data=32'hE1530004 (S forced, Rd forced to 0).
- LDRB R0,[R1,#4] then STR R2,[R5,#8] back-to-back → 32'hE5D10004 at addr 0, 32'hE5852008 at addr 1, consecutive cycles.
- BEQ imm24=3 with `finish` in the same cycle → 32'h0A000003, then 32'hEAFFFFFE, then `done`=1, `word_count`=2.
- ADDR_W=2: three accepts, then `op_ready`=0 with valid held; `finish` → terminator at addr 3, `word_count`=4.
- DP imm with imm12=12'h105 → no write, `error`=1, `err_code`=01; `start` clears it and restarts at BASE.

Source files
------------

// File: rtl/arm_enc_pkg.sv
// Shared types and constants for the ARM program encoder: descriptor payload,
// opcode classes, DP command values, FSM states and error codes.
package arm_enc_pkg;

    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_MEM = 2'b01,
        CLS_BR  = 2'b10,
        CLS_ILL = 2'b11
    } op_class_e;

    // DP command encodings, kept identical to the ALU decoder's view
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_TERM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [31:0] TERM_WORD = 32'hEAFF_FFFE;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_IMM  = 2'b01;
    localparam logic [1:0] ERR_CMD  = 2'b10;
    localparam logic [1:0] ERR_CLS  = 2'b11;

    typedef struct packed {
        op_class_e   cls;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        load;
        logic        byte_acc;
        logic        up;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [4:0]  shamt;
        logic [11:0] imm12;
        logic [23:0] imm24;
    } arm_op_t;

    function automatic logic is_dp_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD,
            CMD_TST, CMD_CMP, CMD_ORR, CMD_MOV: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_word_encode.sv
// Combinational packer: turns one descriptor into a 32-bit ARM word and
// flags descriptors that cannot be encoded.
module arm_word_encode
    import arm_enc_pkg::*;
(
    input  arm_op_t     op,
    output logic [31:0] word_c,
    output logic [1:0]  err_c
);

    logic        s_bit;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [11:0] src2;

    always_comb begin
        word_c = '0;
        err_c  = ERR_NONE;
        s_bit  = op.s;
        rd     = op.rd;
        rn     = op.rn;
        src2   = '0;
        case (op.cls)
            CLS_DP: begin
                // compare/test ops only set flags, MOV has no first operand
                if (op.cmd == CMD_CMP || op.cmd == CMD_TST) begin
                    s_bit = 1'b1;
                    rd    = 4'd0;
                end
                if (op.cmd == CMD_MOV) begin
                    rn = 4'd0;
                end
                src2 = op.imm ? {4'b0000, op.imm12[7:0]}
                              : {op.shamt, 2'b00, 1'b0, op.rm};
                word_c = {op.cond, 2'b00, op.imm, op.cmd, s_bit, rn, rd, src2};
                if (op.imm && (op.imm12[11:8] != 4'd0)) begin
                    err_c = ERR_IMM;
                end else if (!is_dp_cmd(op.cmd)) begin
                    err_c = ERR_CMD;
                end
            end
            CLS_MEM: begin
                // I bit is inverted for memory ops: 0 means immediate offset
                src2   = op.imm ? op.imm12 : {8'b0000_0000, op.rm};
                word_c = {op.cond, 2'b01, ~op.imm, 1'b1, op.up, op.byte_acc,
                          1'b0, op.load, op.rn, op.rd, src2};
            end
            CLS_BR: begin
                word_c = {op.cond, 4'b1010, op.imm24};
            end
            default: begin
                err_c = ERR_CLS;
            end
        endcase
    end

endmodule

// File: rtl/arm_prog_encoder.sv
// Program loader: accepts descriptors, writes encoded words sequentially to
// imem, appends a branch-to-self terminator on finish.
module arm_prog_encoder
    import arm_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_class,
    input  logic [3:0]        op_cond,
    input  logic [3:0]        op_cmd,
    input  logic              op_s,
    input  logic              op_imm,
    input  logic              op_load,
    input  logic              op_byte,
    input  logic              op_up,
    input  logic [3:0]        op_rd,
    input  logic [3:0]        op_rn,
    input  logic [3:0]        op_rm,
    input  logic [4:0]        op_shamt,
    input  logic [11:0]       op_imm12,
    input  logic [23:0]       op_imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // last slot is held back so the terminator always fits
    localparam int unsigned LIMIT = DEPTH - BASE - 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     count_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_d;
    logic                we_d;
    logic                error_d;
    logic [1:0]          err_code_d;
    logic                accept;
    arm_op_t             op;
    logic [31:0]         enc_word;
    logic [1:0]          enc_err;

    always_comb begin
        op          = '0;
        op.cls      = op_class_e'(op_class);
        op.cond     = op_cond;
        op.cmd      = op_cmd;
        op.s        = op_s;
        op.imm      = op_imm;
        op.load     = op_load;
        op.byte_acc = op_byte;
        op.up       = op_up;
        op.rd       = op_rd;
        op.rn       = op_rn;
        op.rm       = op_rm;
        op.shamt    = op_shamt;
        op.imm12    = op_imm12;
        op.imm24    = op_imm24;
    end

    arm_word_encode u_encode (
        .op     (op),
        .word_c (enc_word),
        .err_c  (enc_err)
    );

    assign accept = op_valid && op_ready;

    // next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        count_d    = word_count;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        we_d       = 1'b0;
        error_d    = error;
        err_code_d = err_code;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_RUN;
                    wptr_d     = ADDR_W'(BASE);
                    count_d    = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_d = ST_TERM;
                end
                if (accept) begin
                    if (enc_err != ERR_NONE) begin
                        state_d    = ST_ERR;
                        error_d    = 1'b1;
                        err_code_d = enc_err;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = wptr_q;
                        wdata_d = enc_word;
                        wptr_d  = ADDR_W'(wptr_q + 1'b1);
                        count_d = (ADDR_W + 1)'(word_count + 1'b1);
                    end
                end
            end
            ST_TERM: begin
                we_d    = 1'b1;
                addr_d  = wptr_q;
                wdata_d = TERM_WORD;
                wptr_d  = ADDR_W'(wptr_q + 1'b1);
                count_d = (ADDR_W + 1)'(word_count + 1'b1);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wptr_q     <= ADDR_W'(BASE);
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_W'(BASE);
            imem_wdata <= '0;
            op_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            word_count <= count_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            op_ready   <= (state_d == ST_RUN) && (count_d < (ADDR_W + 1)'(LIMIT));
            busy       <= (state_d == ST_RUN) || (state_d == ST_TERM);
            done       <= (state_d == ST_DONE);
            error      <= error_d;
            err_code   <= err_code_d;
        end
    end

endmodule

// File: tb/tb_arm_prog_encoder.sv
// Scoreboard bench for arm_prog_encoder with a 4-word imem (ADDR_W=2).
module tb_arm_prog_encoder;
    import arm_enc_pkg::*;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, finish = 1'b0, op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    op_class = 2'b00;
    logic [3:0]    op_cond = '0, op_cmd = '0;
    logic          op_s = 1'b0, op_imm = 1'b0, op_load = 1'b0, op_byte = 1'b0, op_up = 1'b0;
    logic [3:0]    op_rd = '0, op_rn = '0, op_rm = '0;
    logic [4:0]    op_shamt = '0;
    logic [11:0]   op_imm12 = '0;
    logic [23:0]   op_imm24 = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];

    arm_prog_encoder #(.ADDR_W(AW), .BASE(0)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .op_valid(op_valid), .op_ready(op_ready), .op_class(op_class),
        .op_cond(op_cond), .op_cmd(op_cmd), .op_s(op_s), .op_imm(op_imm),
        .op_load(op_load), .op_byte(op_byte), .op_up(op_up),
        .op_rd(op_rd), .op_rn(op_rn), .op_rm(op_rm), .op_shamt(op_shamt),
        .op_imm12(op_imm12), .op_imm24(op_imm24),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // monitor: every imem write must match the head of the expected queue
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    function automatic arm_op_t dp(input logic [3:0] cond, input logic [3:0] cmd,
                                   input logic s, input logic imm,
                                   input logic [3:0] rd, input logic [3:0] rn,
                                   input logic [3:0] rm, input logic [4:0] sh,
                                   input logic [11:0] i12);
        arm_op_t o;
        o = '0;
        o.cls = CLS_DP; o.cond = cond; o.cmd = cmd; o.s = s; o.imm = imm;
        o.rd = rd; o.rn = rn; o.rm = rm; o.shamt = sh; o.imm12 = i12;
        return o;
    endfunction

    function automatic arm_op_t mem(input logic [3:0] cond, input logic imm,
                                    input logic up, input logic byt, input logic ld,
                                    input logic [3:0] rd, input logic [3:0] rn,
                                    input logic [3:0] rm, input logic [11:0] i12);
        arm_op_t o;
        o = '0;
        o.cls = CLS_MEM; o.cond = cond; o.imm = imm; o.up = up; o.byte_acc = byt;
        o.load = ld; o.rd = rd; o.rn = rn; o.rm = rm; o.imm12 = i12;
        return o;
    endfunction

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input arm_op_t o);
        op_class = o.cls;  op_cond = o.cond; op_cmd = o.cmd; op_s = o.s;
        op_imm = o.imm;    op_load = o.load; op_byte = o.byte_acc; op_up = o.up;
        op_rd = o.rd;      op_rn = o.rn;     op_rm = o.rm; op_shamt = o.shamt;
        op_imm12 = o.imm12; op_imm24 = o.imm24;
    endtask

    task automatic idle();
        op_valid = 1'b0;
        finish   = 1'b0;
    endtask

    // called just after a negedge; returns just after the next negedge
    task automatic xfer(input arm_op_t o, input logic fin);
        int n;
        drive(o);
        op_valid = 1'b1;
        finish   = fin;
        n = 0;
        while (!op_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("accept_timeout", 32'(op_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int wc);
        int n;
        n = 0;
        while (!done && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(done), 32'd1);
        chk("word_count", 32'(word_count), 32'(wc));
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_err(input logic [1:0] code);
        int n;
        n = 0;
        while (!error && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("error", 32'(error), 32'd1);
        chk("err_code", 32'(err_code), 32'(code));
        chk("busy_in_err", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
    endtask

    initial begin
        arm_op_t o;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        // ADD imm, then start while RUN (ignored), then CMP with finish
        do_start();
        chk("busy_run", 32'(busy), 32'd1);
        chk("ready_run", 32'(op_ready), 32'd1);
        push(2'd0, 32'hE282_1005);
        xfer(dp(4'hE, CMD_ADD, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 5'd0, 12'h005), 1'b0);
        idle();
        do_start();
        push(2'd1, 32'hE153_0004);
        push(2'd2, TERM_WORD);
        xfer(dp(4'hE, CMD_CMP, 1'b0, 1'b0, 4'd9, 4'd3, 4'd4, 5'd0, 12'h000), 1'b1);
        idle();
        wait_done(3);
        chk("ready_done", 32'(op_ready), 32'd0);

        // LDRB / STR back-to-back, finish on its own
        do_start();
        chk("restart_count", 32'(word_count), 32'd0);
        chk("done_cleared", 32'(done), 32'd0);
        push(2'd0, 32'hE5D1_0004);
        push(2'd1, 32'hE585_2008);
        push(2'd2, TERM_WORD);
        xfer(mem(4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 4'd0, 12'h004), 1'b0);
        xfer(mem(4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 4'd0, 12'h008), 1'b0);
        op_valid = 1'b0;
        finish   = 1'b1;
        @(negedge clk);
        idle();
        wait_done(3);

        // BEQ with finish in the same cycle
        do_start();
        o = '0;
        o.cls = CLS_BR; o.cond = 4'h0; o.imm24 = 24'd3;
        push(2'd0, 32'h0A00_0003);
        push(2'd1, TERM_WORD);
        xfer(o, 1'b1);
        idle();
        wait_done(2);

        // fill to the reservation limit, then finish while stalled
        do_start();
        push(2'd0, 32'hE3A0_1001);
        push(2'd1, 32'hE033_2104);
        push(2'd2, 32'hE717_6008);
        xfer(dp(4'hE, CMD_MOV, 1'b0, 1'b1, 4'd1, 4'd7, 4'd0, 5'd0, 12'h001), 1'b0);
        xfer(dp(4'hE, CMD_EOR, 1'b1, 1'b0, 4'd2, 4'd3, 4'd4, 5'd2, 12'h000), 1'b0);
        xfer(mem(4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd7, 4'd8, 12'h000), 1'b0);
        drive(dp(4'hE, CMD_ADD, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 5'd0, 12'h001));
        op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ready_full", 32'(op_ready), 32'd0);
            chk("count_full", 32'(word_count), 32'd3);
            @(negedge clk);
        end
        push(2'd3, TERM_WORD);
        finish = 1'b1;
        @(negedge clk);
        idle();
        wait_done(4);

        // illegal descriptors, each followed by a fresh start
        do_start();
        xfer(dp(4'hE, CMD_ADD, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 5'd0, 12'h105), 1'b0);
        idle();
        wait_err(ERR_IMM);
        do_start();
        chk("err_cleared", 32'(error), 32'd0);
        chk("err_code_cleared", 32'(err_code), 32'd0);
        xfer(dp(4'hE, 4'b0011, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 5'd0, 12'h000), 1'b0);
        idle();
        wait_err(ERR_CMD);
        do_start();
        o = '0;
        o.cls = CLS_ILL;
        xfer(o, 1'b0);
        idle();
        wait_err(ERR_CLS);
        do_start();
        push(2'd0, 32'hE282_1005);
        push(2'd1, TERM_WORD);
        xfer(dp(4'hE, CMD_ADD, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 5'd0, 12'h005), 1'b1);
        idle();
        wait_done(2);

        // reset right after an accept drops the pending write
        do_start();
        drive(dp(4'hE, CMD_SUB, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 5'd0, 12'h001));
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        op_valid = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
